centroid_calc: RTL and testbench

Computes the per-frame centroid of target-coloured pixels from the video pixel stream and hands it to the Kalman filter as one (z_x, z_y) measurement per frame. Sits directly upstream of the Kalman stage. It accumulates coordinate sums and a hit count over a frame, divides with a sequential divider, and holds the result on a valid/ready handshake until the Kalman stage accepts it.

---
 rtl/centroid_calc_pkg.sv | 15 +
 rtl/centroid_calc_seq_divider.sv | 82 ++++++++
 rtl/centroid_calc.sv | 156 +++++++++++++++
 tb/tb_centroid_calc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/centroid_calc_pkg.sv
// Shared widths and FSM encoding for the centroid stage and the Kalman stage.
package centroid_calc_pkg;

  localparam int unsigned CC_DISP_WIDTH = 11;
  localparam int unsigned CC_CNT_WIDTH  = 22;
  localparam int unsigned CC_SUM_WIDTH  = CC_DISP_WIDTH + CC_CNT_WIDTH;
  localparam int unsigned CC_MIN_COUNT  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_OUTPUT = 2'd2
  } cc_state_t;

endpackage

// File: rtl/centroid_calc_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// The first step is taken on the start edge itself, so done pulses exactly
// DVD_W cycles after the start cycle with the final quotient already held.
module seq_divider
  import centroid_calc_pkg::*;
#(
  parameter int unsigned DVD_W = CC_SUM_WIDTH,
  parameter int unsigned DVS_W = CC_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             done
);

  localparam int unsigned CW = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] r_rem;
  logic [DVS_W-1:0] r_dvs;
  logic [DVD_W-1:0] r_quo;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;

  logic [DVS_W-1:0] w_rem_src;
  logic [DVS_W-1:0] w_dvs_src;
  logic [DVD_W-1:0] w_quo_src;
  logic [DVS_W:0]   w_shift;
  logic [DVS_W-1:0] w_diff;
  logic             w_fits;
  logic [DVS_W-1:0] w_rem_next;
  logic [DVD_W-1:0] w_quo_next;

  // One restoring step; on start it works on fresh operands instead of the held ones.
  always_comb begin
    w_rem_src  = start ? '0 : r_rem;
    w_dvs_src  = start ? divisor : r_dvs;
    w_quo_src  = start ? dividend : r_quo;
    w_shift    = {w_rem_src, w_quo_src[DVD_W-1]};
    w_fits     = (w_shift >= {1'b0, w_dvs_src});
    // The true difference is below the divisor whenever it fits, so modulo width is exact.
    w_diff     = w_shift[DVS_W-1:0] - w_dvs_src;
    w_rem_next = w_fits ? w_diff : w_shift[DVS_W-1:0];
    w_quo_next = {w_quo_src[DVD_W-2:0], w_fits};
  end

  // Divider state: operand capture, iteration count and done pulse.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_rem   <= '0;
      r_dvs   <= '0;
      r_quo   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem   <= w_rem_next;
        r_quo   <= w_quo_next;
        r_dvs   <= divisor;
        r_count <= CW'(DVD_W - 1);
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        r_rem   <= w_rem_next;
        r_quo   <= w_quo_next;
        r_count <= r_count - 1'b1;
        if (r_count == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign quotient = r_quo;
  assign done     = r_done;

endmodule

// File: rtl/centroid_calc.sv
// Per-frame centroid of target pixels, delivered as one (z_x, z_y)
// measurement per frame on a valid/ready handshake.
module centroid_calc
  import centroid_calc_pkg::*;
#(
  parameter int unsigned DISP_WIDTH = CC_DISP_WIDTH,
  parameter int unsigned CNT_WIDTH  = CC_CNT_WIDTH,
  parameter int unsigned SUM_WIDTH  = DISP_WIDTH + CNT_WIDTH,
  parameter int unsigned MIN_COUNT  = CC_MIN_COUNT
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  pix_valid,
  input  logic [DISP_WIDTH-1:0] pix_x,
  input  logic [DISP_WIDTH-1:0] pix_y,
  input  logic                  pix_hit,
  input  logic                  frame_end,
  output logic [DISP_WIDTH-1:0] z_x,
  output logic [DISP_WIDTH-1:0] z_y,
  output logic                  valid,
  input  logic                  ready,
  output logic                  no_target,
  output logic                  frame_drop
);

  cc_state_t r_state;
  cc_state_t w_state_next;

  logic [SUM_WIDTH-1:0]  r_sum_x;
  logic [SUM_WIDTH-1:0]  r_sum_y;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DISP_WIDTH-1:0] r_z_x;
  logic [DISP_WIDTH-1:0] r_z_y;
  logic                  r_no_target;
  logic                  r_frame_drop;

  logic                  w_hit;
  logic                  w_idle;
  logic [SUM_WIDTH-1:0]  w_sum_x_fin;
  logic [SUM_WIDTH-1:0]  w_sum_y_fin;
  logic [CNT_WIDTH-1:0]  w_cnt_fin;
  logic                  w_enough;
  logic                  w_start;
  logic [SUM_WIDTH-1:0]  w_quo_x;
  logic [SUM_WIDTH-1:0]  w_quo_y;
  logic                  w_done_x;
  logic                  w_done_y;
  logic                  w_unused;

  // Frame totals including the current-cycle pixel, and the start decision.
  always_comb begin
    w_hit       = pix_valid & pix_hit;
    w_idle      = (r_state == ST_IDLE);
    w_sum_x_fin = r_sum_x + (w_hit ? SUM_WIDTH'(pix_x) : '0);
    w_sum_y_fin = r_sum_y + (w_hit ? SUM_WIDTH'(pix_y) : '0);
    w_cnt_fin   = r_cnt + CNT_WIDTH'(w_hit);
    w_enough    = (w_cnt_fin >= CNT_WIDTH'(MIN_COUNT));
    w_start     = frame_end & w_idle & w_enough;
  end

  // Accumulators; frame_end clears them in any state so the next frame starts clean.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else if (frame_end) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else begin
      r_sum_x <= w_sum_x_fin;
      r_sum_y <= w_sum_y_fin;
      r_cnt   <= w_cnt_fin;
    end
  end

  // Two dividers share the start pulse and the hit count as divisor.
  seq_divider #(
    .DVD_W(SUM_WIDTH),
    .DVS_W(CNT_WIDTH)
  ) u_div_x (
    .clk      (clk),
    .aresetn  (aresetn),
    .start    (w_start),
    .dividend (w_sum_x_fin),
    .divisor  (w_cnt_fin),
    .quotient (w_quo_x),
    .done     (w_done_x)
  );

  seq_divider #(
    .DVD_W(SUM_WIDTH),
    .DVS_W(CNT_WIDTH)
  ) u_div_y (
    .clk      (clk),
    .aresetn  (aresetn),
    .start    (w_start),
    .dividend (w_sum_y_fin),
    .divisor  (w_cnt_fin),
    .quotient (w_quo_y),
    .done     (w_done_y)
  );

  // A mean never exceeds the largest coordinate, so the quotient upper bits are always zero.
  assign w_unused = ^{w_quo_x[SUM_WIDTH-1:DISP_WIDTH], w_quo_y[SUM_WIDTH-1:DISP_WIDTH], w_done_y};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start)  w_state_next = ST_DIVIDE;
      ST_DIVIDE: if (w_done_x) w_state_next = ST_OUTPUT;
      ST_OUTPUT: if (ready)    w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  // One-cycle status pulses for a weak frame or a frame ending while busy.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_no_target  <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_no_target  <= frame_end & w_idle & ~w_enough;
      r_frame_drop <= frame_end & ~w_idle;
    end
  end

  // Measurement registers, loaded once per frame and held through OUTPUT.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_z_x <= '0;
      r_z_y <= '0;
    end else if ((r_state == ST_DIVIDE) && w_done_x) begin
      r_z_x <= w_quo_x[DISP_WIDTH-1:0];
      r_z_y <= w_quo_y[DISP_WIDTH-1:0];
    end
  end

  assign z_x        = r_z_x;
  assign z_y        = r_z_y;
  assign valid      = (r_state == ST_OUTPUT);
  assign no_target  = r_no_target;
  assign frame_drop = r_frame_drop;

endmodule

// File: tb/tb_centroid_calc.sv
// Bench for centroid_calc: frame stimulus with a plain-arithmetic mean model.
module tb_centroid_calc;
  import centroid_calc_pkg::*;

  localparam int unsigned MINC = 4;
  localparam int unsigned DW   = CC_DISP_WIDTH;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_hit = 1'b0;
  logic          frame_end = 1'b0;
  logic          ready = 1'b1;
  logic [DW-1:0] pix_x = '0;
  logic [DW-1:0] pix_y = '0;
  logic [DW-1:0] z_x;
  logic [DW-1:0] z_y;
  logic          valid;
  logic          no_target;
  logic          frame_drop;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] qx[$];
  logic [DW-1:0] qy[$];
  longint exp_sx, exp_sy, exp_cnt;

  always #5 clk = ~clk;

  centroid_calc #(.MIN_COUNT(MINC)) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_hit    (pix_hit),
    .frame_end  (frame_end),
    .z_x        (z_x),
    .z_y        (z_y),
    .valid      (valid),
    .ready      (ready),
    .no_target  (no_target),
    .frame_drop (frame_drop)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    pix_valid = 1'b0;
    pix_hit   = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic add_hits(input int n, input int x, input int y);
    repeat (n) begin
      qx.push_back(DW'(x));
      qy.push_back(DW'(y));
    end
  endtask

  // Drive the queued hits with random filler; the last hit carries frame_end.
  task automatic send_frame();
    exp_sx = 0; exp_sy = 0; exp_cnt = 0;
    if (qx.size() == 0) begin
      @(negedge clk); idle_inputs(); frame_end = 1'b1;
    end
    foreach (qx[i]) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); idle_inputs();
        pix_x = DW'($urandom); pix_y = DW'($urandom);
        if ($urandom_range(0, 1) == 1) begin pix_valid = 1'b1; pix_hit = 1'b0; end
        else begin pix_valid = 1'b0; pix_hit = 1'b1; end
      end
      @(negedge clk); idle_inputs();
      pix_valid = 1'b1; pix_hit = 1'b1; pix_x = qx[i]; pix_y = qy[i];
      exp_sx += longint'(qx[i]); exp_sy += longint'(qy[i]); exp_cnt++;
      frame_end = (i == qx.size() - 1);
    end
    qx.delete(); qy.delete();
  endtask

  // Wait for the measurement; optionally inject a dropped frame ending at cycle drop_at.
  task automatic expect_result(input int hold, input int drop_at);
    logic [DW-1:0] ex, ey;
    int lat;
    ex  = DW'(exp_sx / exp_cnt);
    ey  = DW'(exp_sy / exp_cnt);
    lat = -1;
    ready = (hold == 0);
    for (int k = 1; k <= 120 && lat < 0; k++) begin
      @(negedge clk);
      if (drop_at > 0 && (k == drop_at + 1 || k == drop_at + 2))
        chk("frame_drop", frame_drop, (k == drop_at + 1));
      if (valid) lat = k;
      idle_inputs();
      if (drop_at > 0 && k <= drop_at) begin
        pix_valid = 1'b1; pix_hit = 1'b1;
        pix_x = DW'($urandom); pix_y = DW'($urandom);
        frame_end = (k == drop_at);
      end else if (drop_at == 0 && $urandom_range(0, 1) == 1) begin
        pix_valid = 1'b1; pix_x = DW'($urandom); pix_y = DW'($urandom);
      end
    end
    if (lat < 0) begin
      chk("valid_timeout", 0, 1);
    end else begin
      chk("valid_latency", lat, CC_SUM_WIDTH + 1);
      chk("z_x", z_x, ex);
      chk("z_y", z_y, ey);
      repeat (hold) begin
        @(negedge clk);
        chk("hold_valid", valid, 1);
        chk("hold_z_x", z_x, ex);
        chk("hold_z_y", z_y, ey);
      end
      ready = 1'b1;
      @(negedge clk);
      chk("valid_after_xfer", valid, 0);
    end
    idle_inputs();
    ready = 1'b1;
  endtask

  task automatic expect_no_target();
    bit seen;
    @(negedge clk); idle_inputs();
    chk("no_target", no_target, 1);
    @(negedge clk);
    chk("no_target_width", no_target, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    chk("no_valid_weak_frame", seen, 0);
  endtask

  initial begin
    bit seen;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_z_x", z_x, 0);
    chk("rst_z_y", z_y, 0);
    chk("rst_valid", valid, 0);
    chk("rst_no_target", no_target, 0);
    chk("rst_frame_drop", frame_drop, 0);
    aresetn = 1'b1;

    add_hits(MINC, 100, 200);
    send_frame(); expect_result(0, 0);

    add_hits(1, 10, 10); add_hits(1, 11, 10); add_hits(1, 10, 11); add_hits(1, 11, 11);
    send_frame(); expect_result(0, 0);

    add_hits(16, 2047, 1023);
    send_frame(); expect_result(0, 0);

    add_hits(MINC - 1, 300, 400);
    send_frame(); expect_no_target();
    send_frame(); expect_no_target();

    add_hits(MINC, 7, 9); add_hits(3, 1500, 33);
    send_frame(); expect_result(50, 0);

    for (int i = 0; i < 6; i++) add_hits(1, $urandom_range(0, 2047), $urandom_range(0, 2047));
    send_frame(); expect_result(0, 10);
    for (int i = 0; i < 9; i++) add_hits(1, $urandom_range(0, 2047), $urandom_range(0, 2047));
    send_frame(); expect_result(1, 0);

    add_hits(5, 900, 600);
    send_frame();
    repeat (15) begin @(negedge clk); idle_inputs(); end
    aresetn = 1'b0;
    @(negedge clk);
    chk("midrst_z_x", z_x, 0);
    chk("midrst_z_y", z_y, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_no_target", no_target, 0);
    chk("midrst_frame_drop", frame_drop, 0);
    aresetn = 1'b1;
    seen = 1'b0;
    repeat (50) begin @(negedge clk); if (valid) seen = 1'b1; end
    chk("midrst_no_valid", seen, 0);
    add_hits(MINC, 5, 7);
    send_frame(); expect_result(0, 0);

    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(0, 24);
      for (int i = 0; i < n; i++) add_hits(1, $urandom_range(0, 2047), $urandom_range(0, 2047));
      send_frame();
      if (n >= int'(MINC)) expect_result($urandom_range(0, 3), 0);
      else expect_no_target();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
